// File: rtl/fifo_wr_arbiter.sv
// Round-robin, frame-locking arbiter sharing one FIFO write port between two
// byte-stream requesters; a grant lasts until LAST or the MAX_BURST cap.
module fifo_wr_arbiter #(
    parameter int Data_Width = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  FIFO_Full,
    input  logic                  REQ0,
    input  logic [Data_Width-1:0] DATA0,
    input  logic                  LAST0,
    input  logic                  REQ1,
    input  logic [Data_Width-1:0] DATA1,
    input  logic                  LAST1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic                  W_INC,
    output logic [Data_Width-1:0] W_DATA,
    output logic                  BUSY,
    output logic                  OVF
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CAP_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT0_S = 2'd1,
        GNT1_S = 2'd2
    } state_t;

    state_t          state_r;
    logic            gnt0_r;
    logic            gnt1_r;
    logic            busy_r;
    logic            ovf_r;
    logic            last_r;     // 1: requester 1 was served last
    logic [CW-1:0]   beat_r;

    logic                  xfer0_s;
    logic                  xfer1_s;
    logic                  xfer_s;
    logic                  cur_last_s;
    logic [Data_Width-1:0] w_data_s;

    // Transfer qualification and write-port mux; nothing is written while full.
    always_comb begin
        xfer0_s    = gnt0_r & REQ0 & ~FIFO_Full;
        xfer1_s    = gnt1_r & REQ1 & ~FIFO_Full;
        xfer_s     = xfer0_s | xfer1_s;
        cur_last_s = gnt1_r ? LAST1 : LAST0;
        if (xfer0_s) begin
            w_data_s = DATA0;
        end else if (xfer1_s) begin
            w_data_s = DATA1;
        end else begin
            w_data_s = {Data_Width{1'b0}};
        end
    end

    assign ACK0   = xfer0_s;
    assign ACK1   = xfer1_s;
    assign W_INC  = xfer_s;
    assign W_DATA = w_data_s;
    assign GNT0   = gnt0_r;
    assign GNT1   = gnt1_r;
    assign BUSY   = busy_r;
    assign OVF    = ovf_r;

    // Arbitration state machine with registered grant, busy and overflow flags.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
            last_r  <= 1'b1;
            beat_r  <= {CW{1'b0}};
        end else begin
            ovf_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (EN && REQ0 && (!REQ1 || last_r)) begin
                        state_r <= GNT0_S;
                        gnt0_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        beat_r  <= {CW{1'b0}};
                    end else if (EN && REQ1) begin
                        state_r <= GNT1_S;
                        gnt1_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        beat_r  <= {CW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT0_S, GNT1_S: begin
                    if (xfer_s) begin
                        // A LAST beat that also hits the cap is a normal end.
                        if (cur_last_s || (beat_r == CAP_BEAT)) begin
                            state_r <= IDLE;
                            gnt0_r  <= 1'b0;
                            gnt1_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            last_r  <= (state_r == GNT1_S);
                            ovf_r   <= ~cur_last_s;
                        end else begin
                            beat_r <= beat_r + CW'(1);
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt0_r  <= 1'b0;
                    gnt1_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared each
// cycle against a frame-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int MAXB = 4;

    logic       CLK = 1'b0;
    logic       RST, EN, FIFO_Full;
    logic       REQ0, LAST0, REQ1, LAST1;
    logic [7:0] DATA0, DATA1;
    logic       GNT0, GNT1, ACK0, ACK1, W_INC, BUSY, OVF;
    logic [7:0] W_DATA;

    fifo_wr_arbiter #(.Data_Width(8), .MAX_BURST(MAXB)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .FIFO_Full(FIFO_Full),
        .REQ0(REQ0), .DATA0(DATA0), .LAST0(LAST0),
        .REQ1(REQ1), .DATA1(DATA1), .LAST1(LAST1),
        .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
        .W_INC(W_INC), .W_DATA(W_DATA), .BUSY(BUSY), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Pending bytes per requester: bit 8 marks the frame's last byte.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int gq[$];
    int wr_cnt, ovf_cnt;
    logic p_gnt0 = 1'b0, p_gnt1 = 1'b0;

    logic en_v = 1'b1, full_v = 1'b0, rst_v = 1'b0, gap0_v = 1'b0, gap1_v = 1'b0;

    // Reference model: who owns the port, beats in this frame, who was served last.
    int m_owner  = -1;
    int m_beats  = 0;
    int m_served = 1;
    bit m_ovf    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int r, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            if (r == 0) q0.push_back({(i == len - 1), base + 8'(i)});
            else        q1.push_back({(i == len - 1), base + 8'(i)});
        end
    endtask

    task automatic drive();
        RST       = rst_v;
        EN        = en_v;
        FIFO_Full = full_v;
        REQ0  = (q0.size() > 0) && !gap0_v;
        DATA0 = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        LAST0 = (q0.size() > 0) ? q0[0][8] : 1'b0;
        REQ1  = (q1.size() > 0) && !gap1_v;
        DATA1 = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        LAST1 = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    task automatic run(input int n);
        bit         e_ack0, e_ack1, ended;
        logic [7:0] e_data;
        for (int i = 0; i < n; i++) begin
            drive();
            @(negedge CLK);
            e_ack0 = (m_owner == 0) && REQ0 && !full_v;
            e_ack1 = (m_owner == 1) && REQ1 && !full_v;
            e_data = e_ack0 ? DATA0 : (e_ack1 ? DATA1 : 8'h00);
            chk("gnt0",   {31'd0, GNT0},  {31'd0, m_owner == 0});
            chk("gnt1",   {31'd0, GNT1},  {31'd0, m_owner == 1});
            chk("busy",   {31'd0, BUSY},  {31'd0, m_owner != -1});
            chk("ovf",    {31'd0, OVF},   {31'd0, m_ovf});
            chk("ack0",   {31'd0, ACK0},  {31'd0, e_ack0});
            chk("ack1",   {31'd0, ACK1},  {31'd0, e_ack1});
            chk("w_inc",  {31'd0, W_INC}, {31'd0, e_ack0 | e_ack1});
            chk("w_data", {24'd0, W_DATA}, {24'd0, e_data});
            if (GNT0 && !p_gnt0) gq.push_back(0);
            if (GNT1 && !p_gnt1) gq.push_back(1);
            p_gnt0 = GNT0;
            p_gnt1 = GNT1;
            wr_cnt  += int'(W_INC);
            ovf_cnt += int'(OVF);
            // Advance the model on the values the coming edge will sample.
            if (!rst_v) begin
                m_owner = -1; m_beats = 0; m_served = 1; m_ovf = 1'b0;
            end else if (m_owner == -1) begin
                m_ovf = 1'b0;
                if (en_v && REQ0 && REQ1) m_owner = 1 - m_served;
                else if (en_v && REQ0)    m_owner = 0;
                else if (en_v && REQ1)    m_owner = 1;
                m_beats = 0;
            end else begin
                m_ovf = 1'b0;
                if (e_ack0 || e_ack1) begin
                    m_beats++;
                    ended = e_ack0 ? LAST0 : LAST1;
                    if (ended || m_beats == MAXB) begin
                        m_ovf    = !ended;
                        m_served = m_owner;
                        m_owner  = -1;
                    end
                end
            end
            if (e_ack0) void'(q0.pop_front());
            if (e_ack1) void'(q1.pop_front());
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        drive();
        @(posedge CLK);
        #1;
        run(3);
        rst_v = 1'b1;

        // Single one-byte frame.
        push_frame(0, 1, 8'hA5);
        run(4);
        chk("single_idle_busy", {31'd0, BUSY}, 32'd0);

        // Fresh reset, then three 2-byte frames per requester: strict alternation.
        rst_v = 1'b0; run(1); rst_v = 1'b1;
        gq.delete();
        for (int f = 0; f < 3; f++) begin
            push_frame(0, 2, 8'h10 + 8'(2 * f));
            push_frame(1, 2, 8'h20 + 8'(2 * f));
        end
        run(22);
        chk("rr_grants", gq.size(), 32'd6);
        for (int k = 0; k < 6 && k < gq.size(); k++) chk("rr_order", gq[k], k % 2);

        // Six-byte frame from requester 1 is split by the burst cap.
        gq.delete(); wr_cnt = 0; ovf_cnt = 0;
        push_frame(1, 6, 8'h30);
        run(12);
        chk("cap_writes", wr_cnt, 32'd6);
        chk("cap_ovf_pulses", ovf_cnt, 32'd1);
        chk("cap_regrants", gq.size(), 32'd2);

        // FIFO full for three cycles inside a frame.
        wr_cnt = 0;
        push_frame(0, 4, 8'h40);
        run(2);
        full_v = 1'b1; run(3);
        full_v = 1'b0; run(6);
        chk("full_writes", wr_cnt, 32'd4);

        // EN dropped mid-frame with requester 1 waiting.
        push_frame(0, 3, 8'h50);
        run(2);
        en_v = 1'b0;
        push_frame(1, 1, 8'h60);
        run(8);
        chk("en_hold_gnt1", {31'd0, GNT1}, 32'd0);
        chk("en_hold_busy", {31'd0, BUSY}, 32'd0);
        en_v = 1'b1;
        run(1);
        chk("en_regrant", {31'd0, GNT1}, 32'd1);
        run(3);

        // Reset on a granted transfer cycle.
        push_frame(0, 4, 8'h70);
        run(2);
        rst_v = 1'b0;
        run(1);
        chk("rst_gnt0", {31'd0, GNT0}, 32'd0);
        chk("rst_gnt1", {31'd0, GNT1}, 32'd0);
        chk("rst_ovf",  {31'd0, OVF},  32'd0);
        chk("rst_winc", {31'd0, W_INC}, 32'd0);
        rst_v = 1'b1;
        q0.delete(); q1.delete(); gq.delete();
        push_frame(0, 1, 8'h80);
        push_frame(1, 1, 8'h90);
        run(5);
        chk("rst_tie_winner", (gq.size() > 0) ? gq[0] : -1, 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && $urandom_range(3, 0) == 0)
                push_frame(0, $urandom_range(7, 1), 8'($urandom));
            if (q1.size() == 0 && $urandom_range(3, 0) == 0)
                push_frame(1, $urandom_range(7, 1), 8'($urandom));
            full_v = ($urandom_range(4, 0) == 0);
            en_v   = ($urandom_range(9, 0) != 0);
            gap0_v = ($urandom_range(5, 0) == 0);
            gap1_v = ($urandom_range(5, 0) == 0);
            rst_v  = ($urandom_range(149, 0) != 0);
            if (!rst_v) begin
                q0.delete(); q1.delete();
            end
            run(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
